piece_move_sequencer: RTL and testbench

Per-frame controller that turns keyboard state and gravity timing into at most one lateral/rotate move plus one gravity step per frame for the falling piece. It sits between the keycode export, the VGA vertical-sync frame clock and the board/block datapath. Moves are granted only when the board reports them legal and idle. When a gravity step is blocked, it sequences piece lock and then requests a new block.

---
 rtl/piece_move_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_piece_move_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_move_sequencer.sv
// piece_move_sequencer: per-frame move/gravity controller for the falling piece.
// Turns keyboard state and VGA frame timing into at most one key move plus one
// gravity step per frame, and sequences lock/spawn when gravity is blocked.
//
// Ports:
//   Clk           in   system clock
//   Reset         in   synchronous active-high reset
//   frame_clk     in   VGA vertical sync, asynchronous to Clk
//   keycode[7:0]  in   current key code, 0 = no key
//   can_move[4:0] in   legality: left, right, down, rot-left, rot-right
//   board_busy    in   board updating, can_move not valid
//   lock_done     in   pulse: board finished merging the piece
//   move_apply    out  one-hot pulse committing a move (bit order as can_move)
//   lock_req      out  pulse: lock the current piece
//   get_new_block out  pulse: spawn the next piece
module piece_move_sequencer #(
    parameter int          DROP_FRAMES      = 30,
    parameter int          SOFT_DROP_FRAMES = 3,
    parameter int          REPEAT_DELAY     = 12,
    parameter int          REPEAT_RATE      = 4,
    parameter logic [7:0]  KEY_LEFT         = 8'h04,
    parameter logic [7:0]  KEY_RIGHT        = 8'h07,
    parameter logic [7:0]  KEY_DOWN         = 8'h16,
    parameter logic [7:0]  KEY_ROT_L        = 8'h14,
    parameter logic [7:0]  KEY_ROT_R        = 8'h08
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [4:0] can_move,
    input  logic       board_busy,
    input  logic       lock_done,
    output logic [4:0] move_apply,
    output logic       lock_req,
    output logic       get_new_block
);

    localparam int GW = $clog2(DROP_FRAMES + 1);
    localparam logic [GW-1:0] DROP_M1 = GW'(DROP_FRAMES - 1);
    localparam logic [GW-1:0] SOFT_M1 = GW'(SOFT_DROP_FRAMES - 1);
    localparam logic [7:0]    DLY     = 8'(REPEAT_DELAY);
    localparam logic [7:0]    RATE_M1 = 8'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_KEY,
        S_GRAV,
        S_SETTLE,
        S_LOCK,
        S_SPAWN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]    r_sync;
    logic          r_tick;
    logic [7:0]    r_last_key;
    logic [7:0]    r_hold;
    logic [7:0]    r_rep;
    logic [GW-1:0] r_grav_cnt;
    logic          r_grav_pend;
    logic          r_key_pend;
    logic [2:0]    r_key_bit;
    logic [4:0]    r_move_apply;
    logic          r_lock_req;
    logic          r_get_new;

    logic [7:0]    w_key;
    logic [2:0]    w_bit;
    logic          w_act;
    logic          w_is_lr;
    logic          w_press;
    logic          w_held;
    logic [7:0]    w_hold_inc;
    logic          w_rep_hit;
    logic          w_fire;
    logic [GW-1:0] w_period_m1;
    logic          w_grav_due;
    logic          w_locked;
    logic [4:0]    w_move;
    logic          w_lock;
    logic          w_gnb;

    assign move_apply    = r_move_apply;
    assign lock_req      = r_lock_req;
    assign get_new_block = r_get_new;

    // Two-flop synchronizer ([0],[1]) plus a delayed copy ([2]) for edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync <= 3'b000;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], frame_clk};
            r_tick <= r_sync[1] & ~r_sync[2];
        end
    end

    // Unknown codes collapse to 0 so they behave exactly like "no key".
    always_comb begin
        w_key   = keycode;
        w_bit   = 3'd0;
        w_act   = 1'b0;
        w_is_lr = 1'b0;
        case (keycode)
            KEY_LEFT: begin
                w_bit   = 3'd0;
                w_act   = 1'b1;
                w_is_lr = 1'b1;
            end
            KEY_RIGHT: begin
                w_bit   = 3'd1;
                w_act   = 1'b1;
                w_is_lr = 1'b1;
            end
            KEY_ROT_L: begin
                w_bit = 3'd3;
                w_act = 1'b1;
            end
            KEY_ROT_R: begin
                w_bit = 3'd4;
                w_act = 1'b1;
            end
            KEY_DOWN: begin
                w_bit = 3'd0;
            end
            default: w_key = 8'h00;
        endcase
    end

    assign w_press    = w_act & (w_key != r_last_key);
    assign w_held     = w_is_lr & (w_key == r_last_key);
    assign w_hold_inc = (r_hold == 8'hFF) ? 8'hFF : r_hold + 8'd1;
    // r_rep counts ticks since the last repeat once the delay has elapsed.
    assign w_rep_hit  = (w_hold_inc > DLY) & (r_rep == RATE_M1);
    assign w_fire     = w_press
                      | (w_held & ((w_hold_inc == DLY) | w_rep_hit));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_key <= 8'h00;
            r_hold     <= 8'h00;
            r_rep      <= 8'h00;
        end else begin
            if (r_tick) begin
                r_last_key <= w_key;
                if (w_press) begin
                    r_hold <= 8'h00;
                    r_rep  <= 8'h00;
                end else if (w_held) begin
                    r_hold <= w_hold_inc;
                    if (w_hold_inc == DLY) begin
                        r_rep <= 8'h00;
                    end else if (w_hold_inc > DLY) begin
                        r_rep <= w_rep_hit ? 8'h00 : r_rep + 8'd1;
                    end
                end else begin
                    r_hold <= 8'h00;
                    r_rep  <= 8'h00;
                end
            end
            if (r_state == S_SPAWN) begin
                r_hold <= 8'h00;
                r_rep  <= 8'h00;
            end
        end
    end

    assign w_period_m1 = (keycode == KEY_DOWN) ? SOFT_M1 : DROP_M1;
    assign w_grav_due  = r_grav_cnt >= w_period_m1;
    assign w_locked    = (r_state == S_LOCK) | (r_state == S_SPAWN);

    // A new gravity period landing in the GRAV cycle wins over the clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
        end else begin
            if (w_locked) begin
                r_grav_cnt <= '0;
            end else if (r_tick) begin
                r_grav_cnt <= w_grav_due ? '0 : r_grav_cnt + 1'b1;
            end
            if (r_state == S_GRAV) begin
                r_grav_pend <= 1'b0;
            end
            if (r_tick && !w_locked && w_grav_due) begin
                r_grav_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_pend <= 1'b0;
            r_key_bit  <= 3'd0;
        end else if (r_state == S_IDLE && r_tick) begin
            r_key_pend <= w_fire;
            r_key_bit  <= w_bit;
        end else if (r_state == S_KEY || r_state == S_SPAWN) begin
            r_key_pend <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_move = 5'b00000;
        w_lock = 1'b0;
        w_gnb  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_tick) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!board_busy) begin
                    if (r_key_pend)       w_next = S_KEY;
                    else if (r_grav_pend) w_next = S_GRAV;
                    else                  w_next = S_IDLE;
                end
            end
            S_KEY: begin
                if (can_move[r_key_bit]) w_move[r_key_bit] = 1'b1;
                w_next = S_SETTLE;
            end
            S_GRAV: begin
                if (can_move[2]) begin
                    w_move[2] = 1'b1;
                    w_next    = S_SETTLE;
                end else begin
                    w_lock = 1'b1;
                    w_next = S_LOCK;
                end
            end
            S_SETTLE: w_next = S_WAIT;
            // The spawn pulse is registered here so it appears during SPAWN.
            S_LOCK: begin
                if (lock_done) begin
                    w_gnb  = 1'b1;
                    w_next = S_SPAWN;
                end
            end
            S_SPAWN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_move_apply <= 5'b00000;
            r_lock_req   <= 1'b0;
            r_get_new    <= 1'b0;
        end else begin
            r_move_apply <= w_move;
            r_lock_req   <= w_lock;
            r_get_new    <= w_gnb;
        end
    end

endmodule

// File: tb/tb_piece_move_sequencer.sv
// tb_piece_move_sequencer: randomized frame-level bench with a rule-based
// model that schedules every expected output pulse by absolute cycle.
module tb_piece_move_sequencer;

    localparam int DROP  = 4;
    localparam int SOFT  = 3;
    localparam int DLY   = 12;
    localparam int RATE  = 4;
    localparam int FRAME = 32;
    localparam logic [7:0] K_L  = 8'h04;
    localparam logic [7:0] K_R  = 8'h07;
    localparam logic [7:0] K_D  = 8'h16;
    localparam logic [7:0] K_RL = 8'h14;
    localparam logic [7:0] K_RR = 8'h08;

    logic       Clk        = 1'b0;
    logic       Reset      = 1'b1;
    logic       frame_clk  = 1'b0;
    logic [7:0] keycode    = 8'h00;
    logic [4:0] can_move   = 5'h00;
    logic       board_busy = 1'b0;
    logic       lock_done  = 1'b0;
    logic [4:0] move_apply;
    logic       lock_req;
    logic       get_new_block;

    piece_move_sequencer #(
        .DROP_FRAMES     (DROP),
        .SOFT_DROP_FRAMES(SOFT),
        .REPEAT_DELAY    (DLY),
        .REPEAT_RATE     (RATE)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .can_move     (can_move),
        .board_busy   (board_busy),
        .lock_done    (lock_done),
        .move_apply   (move_apply),
        .lock_req     (lock_req),
        .get_new_block(get_new_block)
    );

    always #5 Clk = ~Clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // model state
    int m_last  = 0;
    int m_hold  = 0;
    int m_gcnt  = 0;
    bit m_lock  = 0;
    int m_spawn = 0;

    // expected pulses keyed by absolute cycle
    logic [4:0] s_mv  [int];
    bit         s_lr  [int];
    bit         s_gnb [int];
    bit         s_ld  [int];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h want %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        int e_mv;
        int e_lr;
        int e_gnb;
        e_mv  = s_mv.exists(cyc) ? int'(s_mv[cyc]) : 0;
        e_lr  = s_lr.exists(cyc) ? 1 : 0;
        e_gnb = s_gnb.exists(cyc) ? 1 : 0;
        chk("move_apply", int'(move_apply), e_mv);
        chk("lock_req", int'(lock_req), e_lr);
        chk("get_new_block", int'(get_new_block), e_gnb);
    endtask

    task automatic model_reset();
        m_last = 0;
        m_hold = 0;
        m_gcnt = 0;
        m_lock = 0;
        s_mv.delete();
        s_lr.delete();
        s_gnb.delete();
        s_ld.delete();
    endtask

    task automatic reset_seq();
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (i > 0) begin
                chk("rst_move_apply", int'(move_apply), 0);
                chk("rst_lock_req", int'(lock_req), 0);
                chk("rst_get_new_block", int'(get_new_block), 0);
            end
            Reset      = 1'b1;
            frame_clk  = (i < 24) ? ((i / 3) % 2 == 1) : 1'b0;
            board_busy = 1'b0;
            lock_done  = 1'b0;
            cyc++;
        end
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("post_rst_move_apply", int'(move_apply), 0);
            chk("post_rst_lock_req", int'(lock_req), 0);
            chk("post_rst_get_new_block", int'(get_new_block), 0);
            Reset = 1'b0;
            cyc++;
        end
    endtask

    task automatic run_frame(input logic [7:0] key, input logic [4:0] cm,
                             input int busy_len, input int lock_dly,
                             input int ncyc);
        int c0;
        int k;
        int bitn;
        int per;
        int off;
        int goff;
        bit act;
        bit lr;
        bit fire;
        bit due;
        c0 = cyc;
        if (m_lock && m_spawn < c0 + 3) begin
            m_lock = 0;
            m_hold = 0;
            m_gcnt = 0;
        end
        k    = int'(key);
        act  = 0;
        lr   = 0;
        bitn = 0;
        case (key)
            K_L:  begin act = 1; lr = 1; bitn = 0; end
            K_R:  begin act = 1; lr = 1; bitn = 1; end
            K_RL: begin act = 1; bitn = 3; end
            K_RR: begin act = 1; bitn = 4; end
            K_D:  ;
            default: k = 0;
        endcase
        fire = 0;
        if (act && k != m_last) begin
            fire   = 1;
            m_hold = 0;
        end else if (lr && k == m_last) begin
            if (m_hold < 255) m_hold++;
            fire = (m_hold == DLY)
                || (m_hold > DLY && (m_hold - DLY) % RATE == 0);
        end else begin
            m_hold = 0;
        end
        m_last = k;
        if (!m_lock) begin
            per = (key == K_D) ? SOFT : DROP;
            due = (m_gcnt >= per - 1);
            if (due) m_gcnt = 0;
            else     m_gcnt++;
            off  = 6 + busy_len;
            goff = off;
            if (fire) begin
                if (cm[bitn]) s_mv[c0 + off] = 5'(1 << bitn);
                goff = off + 3;
            end
            if (due) begin
                if (cm[2]) begin
                    s_mv[c0 + goff] = 5'b00100;
                end else begin
                    s_lr[c0 + goff] = 1;
                    s_ld[c0 + goff + lock_dly] = 1;
                    s_gnb[c0 + goff + lock_dly + 1] = 1;
                    m_spawn = c0 + goff + lock_dly + 1;
                    m_lock  = 1;
                    m_gcnt  = 0;
                end
            end
        end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clk);
            check_outputs();
            frame_clk  = (i < FRAME / 2);
            keycode    = key;
            can_move   = cm;
            board_busy = (i >= 4 && i < 4 + busy_len);
            lock_done  = s_ld.exists(cyc);
            cyc++;
        end
    endtask

    task automatic align_grav();
        run_frame(8'h00, 5'h1F, 0, 10, FRAME);
        for (int n = 0; n < DROP && m_gcnt != DROP - 1; n++)
            run_frame(8'h00, 5'h1F, 0, 10, FRAME);
    endtask

    initial begin
        logic [7:0] rk;
        logic [4:0] rc;
        rk = 8'h00;
        reset_seq();

        repeat (8) run_frame(8'h00, 5'h1F, 0, 10, FRAME);

        repeat (20) run_frame(K_L, 5'h1F, 0, 10, FRAME);
        repeat (5) run_frame(K_RL, 5'h1F, 0, 10, FRAME);

        repeat (4) run_frame(K_R, 5'b11101, 0, 10, FRAME);

        align_grav();
        run_frame(K_R, 5'h1F, 5, 10, FRAME);

        align_grav();
        run_frame(8'h00, 5'b11011, 0, 10, FRAME);
        repeat (2) run_frame(8'h00, 5'h1F, 0, 10, FRAME);

        align_grav();
        run_frame(8'h00, 5'b11011, 0, 50, FRAME);
        repeat (3) run_frame(K_L, 5'h1F, 0, 10, FRAME);

        align_grav();
        run_frame(8'h00, 5'b11011, 0, 60, 20);
        reset_seq();
        repeat (6) run_frame(8'h00, 5'h1F, 0, 10, FRAME);

        repeat (200) begin
            if ($urandom_range(0, 99) < 25) begin
                case ($urandom_range(0, 6))
                    0: rk = 8'h00;
                    1: rk = K_L;
                    2: rk = K_R;
                    3: rk = K_D;
                    4: rk = K_RL;
                    5: rk = K_RR;
                    default: rk = 8'h2A;
                endcase
            end
            rc    = 5'($urandom_range(0, 31));
            rc[2] = ($urandom_range(0, 7) != 0);
            run_frame(rk, rc, int'($urandom_range(0, 3)),
                      int'($urandom_range(2, 12)), FRAME);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
